// File: rtl/snn_img_loader.sv
// Host front end for the SNN core: unpacks a NUM_PIXELS-bit image LSB-first into the input RAM, starts the core, returns the digit byte.
// One byte per 9 cycles in; rx_ready/tx_valid decode from state only. SNN_LOADER_ASCII_EN selects ASCII result encoding.
module snn_img_loader #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we_input,
  output logic [ADDR_W-1:0] addr_wr,
  output logic              d_input,
  output logic              snn_start,
  input  logic              snn_done,
  input  logic [3:0]        snn_digit,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  localparam int NUM_BYTES = NUM_PIXELS / 8;
  localparam int BC_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_RECV,
    S_UNPACK,
    S_START,
    S_WAIT,
    S_SEND
  } state_t;

  state_t            state_q, state_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        shift_q, shift_d;
  logic [3:0]        digit_q, digit_d;
  logic [7:0]        tx_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RECV;
      byte_cnt_q <= '0;
      bit_idx_q  <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      digit_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_idx_q  <= bit_idx_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      digit_q    <= digit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_idx_d  = bit_idx_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    digit_d    = digit_q;
    case (state_q)
      S_RECV: begin
        if (rx_valid) begin
          shift_d   = rx_data;
          bit_idx_d = '0;
          state_d   = S_UNPACK;
        end
      end
      S_UNPACK: begin
        shift_d   = {1'b0, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) begin
          // The last pixel leaves the address at 0 rather than one past the image.
          if (byte_cnt_q == LAST_BYTE) begin
            addr_d     = '0;
            byte_cnt_d = '0;
            state_d    = S_START;
          end else begin
            addr_d     = addr_q + ADDR_W'(1);
            byte_cnt_d = byte_cnt_q + BC_W'(1);
            state_d    = S_RECV;
          end
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (snn_done) begin
          digit_d = snn_digit;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) state_d = S_RECV;
      end
      default: state_d = S_RECV;
    endcase
  end

  always_comb begin
`ifdef SNN_LOADER_ASCII_EN
    tx_byte = (digit_q > 4'd9) ? 8'h3F : (8'h30 + {4'h0, digit_q});
`else
    tx_byte = {4'h0, digit_q};
`endif
  end

  always_comb begin
    rx_ready  = (state_q == S_RECV);
    we_input  = (state_q == S_UNPACK);
    d_input   = (state_q == S_UNPACK) ? shift_q[0] : 1'b0;
    addr_wr   = addr_q;
    snn_start = (state_q == S_START);
    tx_valid  = (state_q == S_SEND);
    tx_data   = (state_q == S_SEND) ? tx_byte : 8'h00;
    // Between bytes of an image the FSM sits in RECV with a nonzero byte count.
    busy      = (state_q != S_RECV) || (byte_cnt_q != '0);
  end

endmodule

// File: tb/tb_snn_img_loader.sv
// Directed bench for snn_img_loader: bit order, full images, result path, spurious done, mid-image reset.
module tb_snn_img_loader;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       we_input;
  logic [9:0] addr_wr;
  logic       d_input;
  logic       snn_start;
  logic       snn_done;
  logic [3:0] snn_digit;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  snn_img_loader #(.NUM_PIXELS(784), .ADDR_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .we_input  (we_input),
    .addr_wr   (addr_wr),
    .d_input   (d_input),
    .snn_start (snn_start),
    .snn_done  (snn_done),
    .snn_digit (snn_digit),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy)
  );

`ifdef SNN_LOADER_ASCII_EN
  localparam int EXP_TX7 = 8'h37;
  localparam int EXP_TX5 = 8'h35;
`else
  localparam int EXP_TX7 = 8'h07;
  localparam int EXP_TX5 = 8'h05;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int stepno = 0;
  int starts = 0;
  int start_step = -1;
  int last_acc = -1;
  int wr_cnt = 0;
  int wr_ones = 0;
  int wr_oob = 0;
  int wr_order_err = 0;
  int exp_wr_addr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    stepno++;
  endtask

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_wr_addr = 0;
    end else if (we_input) begin
      wr_cnt++;
      if (d_input) wr_ones++;
      if (addr_wr >= 10'd784) wr_oob++;
      if (int'(addr_wr) != exp_wr_addr) wr_order_err++;
      exp_wr_addr = (exp_wr_addr == 783) ? 0 : exp_wr_addr + 1;
    end
  end

  task automatic clear_stats();
    starts = 0;
    start_step = -1;
    wr_cnt = 0;
    wr_ones = 0;
    wr_oob = 0;
    wr_order_err = 0;
  endtask

  // Streams n bytes of value v with rx_valid held, then idles 12 cycles past the last accept.
  task automatic feed(input int n, input logic [7:0] v);
    int got;
    int budget;
    got = 0;
    rx_data = v;
    rx_valid = 1'b1;
    budget = n * 9 + 40;
    while (budget > 0) begin
      if (got == n) rx_valid = 1'b0;
      else if (rx_valid && rx_ready) begin
        got++;
        last_acc = stepno;
      end
      if (snn_start) begin
        starts++;
        start_step = stepno;
      end
      if (got == n && stepno >= last_acc + 12) break;
      step();
      budget--;
    end
    rx_valid = 1'b0;
    check_eq("feed_accepts", got, n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    snn_done = 1'b0;
    snn_digit = 4'h0;
    tx_ready = 1'b0;
    step();
    step();
    check_eq("rst_rx_ready", rx_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_we", we_input, 0);
    check_eq("rst_start", snn_start, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_addr", addr_wr, 0);
    check_eq("rst_d", d_input, 0);
    rst = 1'b0;

    // Bit order on byte 0 = 0x01
    rx_data = 8'h01;
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("bo_we", we_input, 1);
      check_eq("bo_addr", addr_wr, i);
      check_eq("bo_d", d_input, (i == 0) ? 1 : 0);
      check_eq("bo_rx_ready", rx_ready, 0);
      check_eq("bo_busy", busy, 1);
    end
    step();
    check_eq("bo_t9_rx_ready", rx_ready, 1);
    check_eq("bo_t9_we", we_input, 0);
    check_eq("bo_t9_busy", busy, 1);
    check_eq("bo_t9_addr", addr_wr, 8);

    // Bytes 1..39, then reset in the middle of byte 40
    feed(39, 8'hAA);
    check_eq("part_no_start", starts, 0);
    check_eq("part_rx_ready", rx_ready, 1);
    rx_data = 8'h55;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check_eq("b40_addr", addr_wr, 320);
    check_eq("b40_d", d_input, 1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mrst_rx_ready", rx_ready, 1);
    check_eq("mrst_addr", addr_wr, 0);
    check_eq("mrst_we", we_input, 0);
    check_eq("mrst_busy", busy, 0);
    check_eq("part_total_no_start", starts, 0);

    // Fresh full image of 0xFF
    clear_stats();
    feed(98, 8'hFF);
    check_eq("img1_starts", starts, 1);
    check_eq("img1_start_lat", start_step - last_acc, 9);
    check_eq("img1_writes", wr_cnt, 784);
    check_eq("img1_ones", wr_ones, 784);
    check_eq("img1_oob", wr_oob, 0);
    check_eq("img1_order", wr_order_err, 0);
    check_eq("wait_rx_ready", rx_ready, 0);
    check_eq("wait_busy", busy, 1);
    check_eq("wait_addr", addr_wr, 0);
    step();
    step();
    check_eq("wait_hold_tx_valid", tx_valid, 0);

    // Result path with tx backpressure
    snn_done = 1'b1;
    snn_digit = 4'd7;
    step();
    snn_done = 1'b0;
    snn_digit = 4'd0;
    for (int i = 0; i < 5; i++) begin
      check_eq("res7_tx_valid", tx_valid, 1);
      check_eq("res7_tx_data", tx_data, EXP_TX7);
      check_eq("res7_rx_ready", rx_ready, 0);
      step();
    end
    check_eq("res7_hold_tx_valid", tx_valid, 1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check_eq("res7_post_tx_valid", tx_valid, 0);
    check_eq("res7_post_busy", busy, 0);
    check_eq("res7_post_rx_ready", rx_ready, 1);

    // Spurious done in RECV and UNPACK
    clear_stats();
    snn_done = 1'b1;
    snn_digit = 4'd3;
    step();
    check_eq("spur_recv_tx_valid", tx_valid, 0);
    check_eq("spur_recv_rx_ready", rx_ready, 1);
    check_eq("spur_recv_busy", busy, 0);
    rx_data = 8'h00;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
    check_eq("spur_unp_tx_valid", tx_valid, 0);
    check_eq("spur_unp_we", we_input, 1);
    check_eq("spur_unp_addr", addr_wr, 1);
    snn_done = 1'b0;
    snn_digit = 4'd0;
    feed(97, 8'hFF);
    check_eq("img2_starts", starts, 1);
    check_eq("img2_start_lat", start_step - last_acc, 9);
    check_eq("img2_writes", wr_cnt, 784);
    check_eq("img2_ones", wr_ones, 776);
    check_eq("img2_order", wr_order_err, 0);
    check_eq("img2_tx_valid", tx_valid, 0);

    snn_done = 1'b1;
    snn_digit = 4'd5;
    tx_ready = 1'b1;
    step();
    snn_done = 1'b0;
    check_eq("res5_tx_valid", tx_valid, 1);
    check_eq("res5_tx_data", tx_data, EXP_TX5);
    step();
    tx_ready = 1'b0;
    check_eq("res5_post_tx_valid", tx_valid, 0);
    check_eq("res5_post_busy", busy, 0);
    check_eq("res5_post_rx_ready", rx_ready, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
